// File: rtl/fifo_wrapper.sv
// rtl/fifo_wrapper.sv - single-clock FIFO with full/empty/count and overflow/underflow pulses
module fifo_wrapper #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    // The extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count   = wr_ptr - rd_ptr;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            overflow  <= push && full && !pop_ok;
            underflow <= pop && empty;
        end
    end

endmodule

// File: tb/tb_fifo_wrapper.sv
// tb/tb_fifo_wrapper.sv - directed self-checking bench for fifo_wrapper
module tb_fifo_wrapper;

    logic       clk;
    logic       rst;
    logic       push;
    logic [7:0] data_in;
    logic       pop;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_cmp;
    int n_bad;

    fifo_wrapper #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .data_in   (data_in),
        .pop       (pop),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic [7:0] d, input logic q);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    task automatic push_chk(input int d, input int exp_count, input logic exp_ovf);
        cyc(1'b1, 8'(d), 1'b0);
        check("push_count", 32'(count), 32'(exp_count));
        check("push_ovf", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic pop_chk(input int exp_data, input logic exp_unf);
        cyc(1'b0, 8'h00, 1'b1);
        check("pop_data", 32'(data_out), 32'(exp_data));
        check("pop_unf", 32'(underflow), 32'(exp_unf));
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        #22;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // basic ordering
        for (int i = 0; i < 11; i++) push_chk(i, i + 1, 1'b0);
        for (int i = 0; i < 11; i++) pop_chk(i, 1'b0);
        check("t1_empty", 32'(empty), 32'd1);

        // overflow then drain past empty
        for (int i = 0; i < 21; i++) begin
            push_chk(i, (i < 16) ? i + 1 : 16, (i >= 16));
            check("t2_full", 32'(full), 32'(i >= 15));
        end
        for (int i = 0; i < 21; i++) begin
            pop_chk((i < 16) ? i : 15, (i >= 16));
            check("t2_ovf_clear", 32'(overflow), 32'd0);
        end

        // underflow with empty held
        for (int i = 0; i < 16; i++) push_chk(i, i + 1, 1'b0);
        for (int i = 0; i < 21; i++) begin
            pop_chk((i < 16) ? i : 15, (i >= 16));
            if (i >= 15) check("t3_empty", 32'(empty), 32'd1);
        end

        // wrap-around rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) push_chk(r * 8 + k, k + 1, 1'b0);
            for (int k = 0; k < 8; k++) pop_chk(r * 8 + k, 1'b0);
            check("wrap_count", 32'(count), 32'd0);
        end

        // simultaneous push+pop at full, mid, empty
        for (int i = 0; i < 16; i++) push_chk(i, i + 1, 1'b0);
        cyc(1'b1, 8'd99, 1'b1);
        check("pp16_count", 32'(count), 32'd16);
        check("pp16_ovf", 32'(overflow), 32'd0);
        check("pp16_data", 32'(data_out), 32'd0);
        for (int i = 1; i < 12; i++) pop_chk(i, 1'b0);
        check("pre5_count", 32'(count), 32'd5);
        cyc(1'b1, 8'd77, 1'b1);
        check("pp5_count", 32'(count), 32'd5);
        check("pp5_ovf", 32'(overflow), 32'd0);
        check("pp5_data", 32'(data_out), 32'd12);
        pop_chk(13, 1'b0);
        pop_chk(14, 1'b0);
        pop_chk(15, 1'b0);
        pop_chk(99, 1'b0);
        pop_chk(77, 1'b0);
        cyc(1'b1, 8'd55, 1'b1);
        check("pp0_count", 32'(count), 32'd1);
        check("pp0_unf", 32'(underflow), 32'd1);
        check("pp0_data", 32'(data_out), 32'd77);
        pop_chk(55, 1'b0);

        // reset mid-operation
        for (int i = 0; i < 7; i++) push_chk(i + 8'h30, i + 1, 1'b0);
        pop_chk(8'h30, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("mr_empty", 32'(empty), 32'd1);
        check("mr_count", 32'(count), 32'd0);
        check("mr_dout", 32'(data_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("mr_ovf", 32'(overflow), 32'd0);
        check("mr_unf", 32'(underflow), 32'd0);
        push_chk(8'hA5, 1, 1'b0);
        pop_chk(8'hA5, 1'b0);
        check("mr_end_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
